rotor_position_startup_sequencer: RTL
=====================================

# rotor_position_startup_sequencer

Sequences motor start-up around the rotor-position/speed front end. Qualifies the hall code, pulses the electrical-angle forecast enable for a fixed window, and waits for the sin/cos valid strobe before releasing the current loop. Sits between the top-level motor command logic and the `speed_and_phase_trig_calculation_module` instance. Supervises hall validity and trig-strobe liveness while running, and latches a coded fault.

## Interface

Parameters:
- `SETTLE_CYCLES`, default 1000: cycles a synchronized hall code must stay unchanged to be accepted.
- `FORECAST_CYCLES`, default 20000: length of the forecast-enable window.
- `TRIG_TIMEOUT`, default 4096: maximum cycles without a trig valid strobe, in `WAIT_TRIG` and in `RUN`.
- `STALL_TIMEOUT`, default 10_000_000: maximum cycles without a hall edge in `RUN` (only with the macro).

Ports (clock and reset first):
- `sys_clk`, in, 1: single system clock.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `motor_start_in`, in, 1: single-cycle start request.
- `motor_stop_in`, in, 1: level stop request.
- `fault_clear_in`, in, 1: single-cycle fault acknowledge.
- `hall_u_in`, `hall_v_in`, `hall_w_in`, in, 1 each: raw asynchronous hall inputs.
- `trig_valid_in`, in, 1: sin/cos calculate valid strobe.
- `phase_forecast_enable_out`, out, 1: drives the forecast enable.
- `current_loop_enable_out`, out, 1: releases the FOC current loop.
- `sequencer_busy_out`, out, 1: high in `HALL_CHECK`, `FORECAST` and `WAIT_TRIG`.
- `fault_out`, out, 1: high in `FAULT`.
- `fault_code_out`, out, 2: 0 = none, 1 = invalid hall, 2 = trig timeout, 3 = hall stall.
- `hall_code_out`, out, 3: qualified hall code `{u,v,w}`.

## Operation

- Hall inputs pass through a 2-FF synchronizer.
- Settle counter: reloads on any change of the synchronized code and saturates at `SETTLE_CYCLES`. The code is "stable" when the counter is saturated.
- The stable code is copied to `hall_code_out`. Code 000 or 111 while stable counts as an invalid hall.

State machine (6 states):
- `IDLE`: `motor_start_in` with `motor_stop_in` low goes to `HALL_CHECK`.
- `HALL_CHECK`:
  - Stable code 1..6 goes to `FORECAST`.
  - Stable invalid code goes to `FAULT`, code 1.
- `FORECAST`: `phase_forecast_enable_out` is high for exactly `FORECAST_CYCLES` cycles, then the block goes to `WAIT_TRIG`.
- `WAIT_TRIG`:
  - First `trig_valid_in` goes to `RUN`.
  - `TRIG_TIMEOUT` cycles with no strobe go to `FAULT`, code 2.
- `RUN`:
  - `current_loop_enable_out` is high.
  - The trig-gap counter reloads on each strobe. Expiry goes to `FAULT`, code 2.
  - Stable invalid hall goes to `FAULT`, code 1.
- `FAULT`:
  - All enables are low.
  - `fault_code_out` holds the first fault.
  - `fault_clear_in` goes to `IDLE`, clears the code, and resets all counters.

Priority rules:
- Fault detection beats stop.
- Stop beats start.
- Trig timeout beats invalid hall when both occur in the same cycle; the code is 2.
- `motor_stop_in` high in any non-`FAULT` state goes to `IDLE` on the next edge.
- `motor_start_in` outside `IDLE` is ignored.
- `FAULT` ignores start and stop.

Width and counter rules:
- Counters are sized by `$clog2` of their parameter.
- Counters never wrap: they saturate or reload.

## Timing

- Reset value of every output is 0.
- Reset forces `IDLE` and asynchronously clears the synchronizer, counters and fault code.
- All outputs are registered and change on the edge where the new state is entered.
- Hall latency: 2 cycles (synchronizer), then `SETTLE_CYCLES` of stability before acceptance.
- Start to `FORECAST`: 1 + 2 + `SETTLE_CYCLES` cycles minimum with clean halls.
- A `trig_valid_in` strobe in cycle N sets `current_loop_enable_out` in cycle N+1.
- A timeout that expires in cycle N puts the block in `FAULT` with `fault_out` high in cycle N+1.

## Configuration

- Macro `HALL_STALL_DETECT_EN`, defined:
  - A stall counter runs in `RUN` and reloads on every synchronized hall edge.
  - Reaching `STALL_TIMEOUT` goes to `FAULT`, code 3.
  - Priority order is code 2, then code 1, then code 3.
- Macro not defined: the stall counter and `STALL_TIMEOUT` logic are absent, and fault code 3 is never produced.

## Structure

- `project_param.v` holds:
  - state encodings: `SEQ_IDLE`, `SEQ_HALL_CHECK`, `SEQ_FORECAST`, `SEQ_WAIT_TRIG`, `SEQ_RUN`, `SEQ_FAULT`;
  - fault code constants: `FAULT_NONE`, `FAULT_HALL`, `FAULT_TRIG`, `FAULT_STALL`;
  - the `HALL_STALL_DETECT_EN` switch.
- One sub-module, `hall_code_qualifier`: synchronizer, settle counter, stable/invalid flags, and edge pulse.
- The FSM and the timeout counters stay in the top module.

## Test plan

All scenarios use SETTLE=4, FORECAST=16, TRIG_TIMEOUT=32, STALL=64.

1. Hall=101 held, start pulse at cycle 10, strobe 5 cycles after forecast ends:
   - `phase_forecast_enable_out` is high for exactly 16 cycles;
   - `current_loop_enable_out` rises 1 cycle after the strobe;
   - `hall_code_out` = 101.
2. Hall=111 held, start:
   - `FAULT` with `fault_code_out` = 1;
   - forecast enable never asserted;
   - after `fault_clear_in` the block returns to `IDLE` with all outputs 0.
3. `RUN` with strobes every 20 cycles, then strobes stop:
   - `fault_out` rises exactly 33 cycles after the last strobe;
   - code = 2.
4. `motor_stop_in` asserted mid-`FORECAST`, together with a start pulse:
   - `IDLE` next cycle, enables low;
   - a later start re-runs the full sequence.
5. Hall toggling 001/011 every 3 cycles, start:
   - the block stays in `HALL_CHECK` (never settles) with `sequencer_busy_out` = 1;
   - `reset_n` pulsed low mid-run clears all outputs to 0 asynchronously.
6. With `HALL_STALL_DETECT_EN`, `RUN` with strobes but hall frozen at 010:
   - `FAULT` code 3 after 64 cycles.
   - Without the macro: no fault after 1000 cycles.

Source files
------------

// File: rtl/rotor_position_startup_sequencer_pkg.sv
// Shared types and constants for the rotor-position start-up sequencer.
// Holds the sequencer state encoding, the fault codes and a hall-code helper.
// The optional hall-stall supervisor is enabled by the HALL_STALL_DETECT_EN macro.
package rotor_position_startup_sequencer_pkg;

    typedef enum logic [2:0] {
        SEQ_IDLE       = 3'd0,
        SEQ_HALL_CHECK = 3'd1,
        SEQ_FORECAST   = 3'd2,
        SEQ_WAIT_TRIG  = 3'd3,
        SEQ_RUN        = 3'd4,
        SEQ_FAULT      = 3'd5
    } seq_state_t;

    localparam logic [1:0] FAULT_NONE  = 2'd0;
    localparam logic [1:0] FAULT_HALL  = 2'd1;
    localparam logic [1:0] FAULT_TRIG  = 2'd2;
    localparam logic [1:0] FAULT_STALL = 2'd3;

    // 000 and 111 cannot occur on a healthy 120-degree hall set.
    function automatic logic hall_code_invalid(input logic [2:0] code);
        return (code == 3'b000) || (code == 3'b111);
    endfunction

endpackage

// File: rtl/rotor_position_startup_sequencer_if.sv
// Command / status bundle between the motor command logic and the sequencer.
// master: command side (drives start/stop/clear, halls, trig strobe).
// slave : sequencer side (drives enables, busy, fault status, hall code).
interface rotor_position_startup_sequencer_if;
    logic       motor_start_in;
    logic       motor_stop_in;
    logic       fault_clear_in;
    logic       hall_u_in;
    logic       hall_v_in;
    logic       hall_w_in;
    logic       trig_valid_in;
    logic       phase_forecast_enable_out;
    logic       current_loop_enable_out;
    logic       sequencer_busy_out;
    logic       fault_out;
    logic [1:0] fault_code_out;
    logic [2:0] hall_code_out;

    modport master (
        output motor_start_in, motor_stop_in, fault_clear_in,
        output hall_u_in, hall_v_in, hall_w_in, trig_valid_in,
        input  phase_forecast_enable_out, current_loop_enable_out,
        input  sequencer_busy_out, fault_out, fault_code_out, hall_code_out
    );

    modport slave (
        input  motor_start_in, motor_stop_in, fault_clear_in,
        input  hall_u_in, hall_v_in, hall_w_in, trig_valid_in,
        output phase_forecast_enable_out, current_loop_enable_out,
        output sequencer_busy_out, fault_out, fault_code_out, hall_code_out
    );
endinterface

// File: rtl/rotor_position_startup_sequencer_hall_code_qualifier.sv
// Hall code qualifier: 2-FF synchronizer, settle counter, stable/invalid
// flags and a synchronized-edge pulse.
// Ports: sys_clk, reset_n (async low), clear (sync counter/code clear),
//        hall_raw[2:0] {u,v,w} async in, hall_code (registered stable code),
//        stable, invalid, hall_edge (synchronized code changes next edge).
module hall_code_qualifier
    import rotor_position_startup_sequencer_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1000
) (
    input  logic       sys_clk,
    input  logic       reset_n,
    input  logic       clear,
    input  logic [2:0] hall_raw,
    output logic [2:0] hall_code,
    output logic       stable,
    output logic       invalid,
    output logic       hall_edge
);
    // Counter must be able to hold SETTLE_CYCLES itself since it saturates there.
    localparam int CW = $clog2(SETTLE_CYCLES + 1);

    logic [2:0]    sync1, sync2;
    logic [CW-1:0] settle_cnt;

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1      <= '0;
            sync2      <= '0;
            settle_cnt <= '0;
            hall_code  <= '0;
        end else begin
            sync1 <= hall_raw;
            sync2 <= sync1;
            if (clear || hall_edge)
                settle_cnt <= '0;
            else if (!stable)
                settle_cnt <= settle_cnt + 1'b1;
            if (clear)
                hall_code <= '0;
            else if (stable)
                hall_code <= sync2;
        end
    end

    assign hall_edge = (sync1 != sync2);
    assign stable    = (settle_cnt == CW'(SETTLE_CYCLES));
    assign invalid   = stable && hall_code_invalid(sync2);

endmodule

// File: rtl/rotor_position_startup_sequencer.sv
// Rotor-position start-up sequencer: qualifies halls, opens the forecast
// window, waits for the sin/cos valid strobe, then releases the current loop.
// Supervises hall validity and trig liveness in RUN and latches a fault code.
// Ports: sys_clk, reset_n (async low), bus (slave modport of
//        rotor_position_startup_sequencer_if).
// Macro HALL_STALL_DETECT_EN: adds a RUN-state hall stall timeout (code 3).
module rotor_position_startup_sequencer
    import rotor_position_startup_sequencer_pkg::*;
#(
    parameter int SETTLE_CYCLES   = 1000,
    parameter int FORECAST_CYCLES = 20000,
    parameter int TRIG_TIMEOUT    = 4096,
    parameter int STALL_TIMEOUT   = 10_000_000
) (
    input logic sys_clk,
    input logic reset_n,
    rotor_position_startup_sequencer_if.slave bus
);
    localparam int FW = $clog2(FORECAST_CYCLES);
    localparam int TW = $clog2(TRIG_TIMEOUT);

    seq_state_t    state, state_next;
    logic [1:0]    fault_code, fault_next;
    logic [FW-1:0] fc_cnt;
    logic [TW-1:0] trig_cnt;
    logic [2:0]    hall_code;
    logic          q_stable, q_invalid, hall_edge;
    logic          fc_done, trig_expired;
    logic          pf_q, cle_q, busy_q, fault_q;

    hall_code_qualifier #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_qual (
        .sys_clk   (sys_clk),
        .reset_n   (reset_n),
        .clear     ((state == SEQ_FAULT) && bus.fault_clear_in),
        .hall_raw  ({bus.hall_u_in, bus.hall_v_in, bus.hall_w_in}),
        .hall_code (hall_code),
        .stable    (q_stable),
        .invalid   (q_invalid),
        .hall_edge (hall_edge)
    );

    assign fc_done      = (fc_cnt == FW'(FORECAST_CYCLES - 1));
    // Expiry: the counter has already seen TRIG_TIMEOUT-1 empty cycles and
    // this one carries no strobe either.
    assign trig_expired = !bus.trig_valid_in && (trig_cnt == TW'(TRIG_TIMEOUT - 1));

`ifdef HALL_STALL_DETECT_EN
    localparam int SW = $clog2(STALL_TIMEOUT);
    logic [SW-1:0] stall_cnt;
    logic          stall_expired;
    assign stall_expired = !hall_edge && (stall_cnt == SW'(STALL_TIMEOUT - 1));

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n)
            stall_cnt <= '0;
        else if (state == SEQ_RUN && state_next == SEQ_RUN && !hall_edge)
            stall_cnt <= stall_cnt + 1'b1;
        else
            stall_cnt <= '0;
    end
`else
    localparam int unused_stall_timeout = STALL_TIMEOUT;
    logic unused_hall_edge;
    assign unused_hall_edge = hall_edge;
`endif

    always_comb begin
        state_next = state;
        fault_next = fault_code;
        case (state)
            SEQ_IDLE:
                if (bus.motor_start_in && !bus.motor_stop_in) state_next = SEQ_HALL_CHECK;
            SEQ_HALL_CHECK:
                if (q_invalid) begin
                    state_next = SEQ_FAULT;
                    fault_next = FAULT_HALL;
                end else if (bus.motor_stop_in)
                    state_next = SEQ_IDLE;
                else if (q_stable)
                    state_next = SEQ_FORECAST;
            SEQ_FORECAST:
                if (bus.motor_stop_in)  state_next = SEQ_IDLE;
                else if (fc_done)       state_next = SEQ_WAIT_TRIG;
            SEQ_WAIT_TRIG:
                if (trig_expired) begin
                    state_next = SEQ_FAULT;
                    fault_next = FAULT_TRIG;
                end else if (bus.motor_stop_in)
                    state_next = SEQ_IDLE;
                else if (bus.trig_valid_in)
                    state_next = SEQ_RUN;
            SEQ_RUN:
                if (trig_expired) begin
                    state_next = SEQ_FAULT;
                    fault_next = FAULT_TRIG;
                end else if (q_invalid) begin
                    state_next = SEQ_FAULT;
                    fault_next = FAULT_HALL;
`ifdef HALL_STALL_DETECT_EN
                end else if (stall_expired) begin
                    state_next = SEQ_FAULT;
                    fault_next = FAULT_STALL;
`endif
                end else if (bus.motor_stop_in)
                    state_next = SEQ_IDLE;
            SEQ_FAULT:
                if (bus.fault_clear_in) begin
                    state_next = SEQ_IDLE;
                    fault_next = FAULT_NONE;
                end
            default:
                state_next = SEQ_IDLE;
        endcase
    end

    // Counters only advance while the state is held; any transition reloads
    // them, so they never wrap and fault-clear leaves them at zero.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= SEQ_IDLE;
            fault_code <= FAULT_NONE;
            fc_cnt     <= '0;
            trig_cnt   <= '0;
            pf_q       <= 1'b0;
            cle_q      <= 1'b0;
            busy_q     <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state      <= state_next;
            fault_code <= fault_next;
            fc_cnt     <= (state == SEQ_FORECAST && state_next == SEQ_FORECAST)
                          ? fc_cnt + 1'b1 : '0;
            trig_cnt   <= ((state == SEQ_WAIT_TRIG || state == SEQ_RUN) &&
                           state_next == state && !bus.trig_valid_in)
                          ? trig_cnt + 1'b1 : '0;
            // Outputs track the state being entered so they change on that edge.
            pf_q       <= (state_next == SEQ_FORECAST);
            cle_q      <= (state_next == SEQ_RUN);
            busy_q     <= (state_next == SEQ_HALL_CHECK) || (state_next == SEQ_FORECAST) ||
                          (state_next == SEQ_WAIT_TRIG);
            fault_q    <= (state_next == SEQ_FAULT);
        end
    end

    assign bus.phase_forecast_enable_out = pf_q;
    assign bus.current_loop_enable_out   = cle_q;
    assign bus.sequencer_busy_out        = busy_q;
    assign bus.fault_out                 = fault_q;
    assign bus.fault_code_out            = fault_code;
    assign bus.hall_code_out             = hall_code;

endmodule
